// File: rtl/led_trail_fader.sv
// -----------------------------------------------------------------------------
// led_trail_fader
//
// Turns the chaser's 8-bit light pattern into 8 PWM-driven LEDs with a fading
// tail. A lit input bit pins its channel at full brightness. Once the bit
// drops, the channel loses DECAY_STEP levels on every decay tick until it
// reaches 0. A single free-running PWM counter renders brightness for all
// channels, so every LED shares one frame.
//
// Parameters
//   LEVEL_W    : brightness resolution in bits, MAX = 2^LEVEL_W - 1
//   DECAY_DIV  : clocks per decay tick (>= 2)
//   DECAY_STEP : levels removed per decay tick (1..MAX)
//
// Ports
//   clk         : single clock, rising edge
//   rst_n       : asynchronous active-low reset
//   enable      : run / pause (pause freezes counters and levels, blanks LEDs)
//   light_in    : pattern from the chaser, any number of bits may be set
//   led_out     : registered PWM drive, one bit per LED
//   frame_start : registered one-cycle pulse at the start of each PWM period
// -----------------------------------------------------------------------------
module led_trail_fader #(
  parameter int LEVEL_W    = 4,
  parameter int DECAY_DIV  = 64,
  parameter int DECAY_STEP = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] light_in,
  output logic [7:0] led_out,
  output logic       frame_start
);

  localparam int MAX_I = (1 << LEVEL_W) - 1;
  localparam int DIV_W = (DECAY_DIV > 2) ? $clog2(DECAY_DIV) : 1;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_I);
  // The PWM period is MAX clocks, so the counter's last value is MAX-1.
  // That way level MAX beats every counter value and gives 100 % duty.
  localparam logic [LEVEL_W-1:0] PWM_LAST   = LEVEL_W'(MAX_I - 1);
  localparam logic [LEVEL_W-1:0] STEP       = LEVEL_W'(DECAY_STEP);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DECAY_DIV - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [LEVEL_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [LEVEL_W-1:0] level_q [8];
  logic [LEVEL_W-1:0] level_d [8];
  logic [7:0]         led_out_q, led_out_d;
  logic               frame_start_q, frame_start_d;

  logic               tick;

  // ---------------------------------------------------------------------------
  // Shared counters
  // ---------------------------------------------------------------------------
  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    div_cnt_d = div_cnt_q;
    if (enable) begin
      pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    end
  end

  assign tick = enable && (div_cnt_q == DIV_LAST);

  // ---------------------------------------------------------------------------
  // Per-channel brightness. A set input wins over a tick in the same cycle.
  // The subtraction only happens after the guard compare, so the level can
  // never wrap below zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      level_d[i] = level_q[i];
      if (enable) begin
        if (light_in[i]) begin
          level_d[i] = LEVEL_MAX;
        end else if (tick) begin
          level_d[i] = (level_q[i] > STEP) ? level_q[i] - STEP : '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output compare. led_out and frame_start both look at the same pwm_cnt
  // sample, so they stay aligned with one clock of latency.
  // ---------------------------------------------------------------------------
  always_comb begin
    led_out_d = '0;
    for (int i = 0; i < 8; i++) begin
      led_out_d[i] = enable && (level_q[i] > pwm_cnt_q);
    end
    frame_start_d = enable && (pwm_cnt_q == '0);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q     <= '0;
      div_cnt_q     <= '0;
      led_out_q     <= '0;
      frame_start_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        level_q[i] <= '0;
      end
    end else begin
      pwm_cnt_q     <= pwm_cnt_d;
      div_cnt_q     <= div_cnt_d;
      led_out_q     <= led_out_d;
      frame_start_q <= frame_start_d;
      for (int i = 0; i < 8; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

  assign led_out     = led_out_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_trail_fader.sv
// -----------------------------------------------------------------------------
// tb_led_trail_fader
//
// Directed bench for led_trail_fader at its default parameters
// (MAX = 15, DECAY_DIV = 64, DECAY_STEP = 3).
//
// "cyc" counts clock edges that saw enable = 1 since the last reset. Because
// both counters start at 0 and only move on those edges, pwm_cnt = cyc % 15
// and ticks land on cyc = 64, 128, 192, ... . Duty is measured as the number
// of cycles a bit is high across 15 consecutive samples, which equals the
// channel level when the level is constant over that window.
// -----------------------------------------------------------------------------
module tb_led_trail_fader;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] light_in;
  logic [7:0] led_out;
  logic       frame_start;

  led_trail_fader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .light_in    (light_in),
    .led_out     (led_out),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int cnt [8];

  // rst   : start a fresh run with light applied before the first edge
  // at    : otherwise run to this cyc, apply light, then measure 15 samples
  // duty  : expected duty per channel, one hex digit each, channel 0 rightmost
  typedef struct {
    bit          rst;
    int          at;
    logic [7:0]  light;
    logic [31:0] duty;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock edge, sampled 1 time unit later. frame_start is checked on
  // every edge: it must pulse exactly when the pre-edge pwm_cnt was 0.
  task automatic step();
    logic en;
    en = enable;
    @(posedge clk);
    #1;
    if (en) begin
      cyc++;
      chk("frame_start", int'(frame_start), int'(((cyc - 1) % 15) == 0));
    end else begin
      chk("frame_start_paused", int'(frame_start), 0);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    enable   = 1'b0;
    light_in = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic measure();
    for (int c = 0; c < 8; c++) cnt[c] = 0;
    repeat (15) begin
      step();
      for (int c = 0; c < 8; c++) if (led_out[c]) cnt[c]++;
    end
  endtask

  task automatic compare_duty(input string tag, input logic [31:0] exp);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("%s_ch%0d", tag, c), cnt[c], int'(exp[4*c +: 4]));
    end
  endtask

  initial begin
    logic [7:0] lastlit;
    int         k;

    // fade trajectory on channel 4: 15, 12, 9, 6, 3, 0, stays 0
    vecs[0]  = '{1'b1, 0,   8'h10, 32'h0000_0000};
    vecs[1]  = '{1'b0, 1,   8'h00, 32'h000F_0000};
    vecs[2]  = '{1'b0, 65,  8'h00, 32'h000C_0000};
    vecs[3]  = '{1'b0, 129, 8'h00, 32'h0009_0000};
    vecs[4]  = '{1'b0, 193, 8'h00, 32'h0006_0000};
    vecs[5]  = '{1'b0, 257, 8'h00, 32'h0003_0000};
    vecs[6]  = '{1'b0, 321, 8'h00, 32'h0000_0000};
    vecs[7]  = '{1'b0, 400, 8'h00, 32'h0000_0000};
    // channel 2 held across ticks stays full; channel 5 fades and hits 3 -> 0
    vecs[8]  = '{1'b1, 0,   8'h24, 32'h0000_0000};
    vecs[9]  = '{1'b0, 1,   8'h04, 32'h00F0_0F00};
    vecs[10] = '{1'b0, 129, 8'h04, 32'h0090_0F00};
    vecs[11] = '{1'b0, 193, 8'h04, 32'h0060_0F00};
    vecs[12] = '{1'b0, 211, 8'h00, 32'h0060_0F00};
    vecs[13] = '{1'b0, 257, 8'h00, 32'h0030_0C00};
    vecs[14] = '{1'b0, 321, 8'h00, 32'h0000_0900};

    // ---- reset values at time zero
    rst_n    = 1'b0;
    enable   = 1'b0;
    light_in = 8'h00;
    #2;
    chk("reset_led_out", int'(led_out), 0);
    chk("reset_frame_start", int'(frame_start), 0);

    // ---- table-driven fade / collision vectors
    for (int v = 0; v < 15; v++) begin
      if (vecs[v].rst) begin
        do_reset();
        light_in = vecs[v].light;
        enable   = 1'b1;
      end else begin
        while (cyc < vecs[v].at) step();
        light_in = vecs[v].light;
        measure();
        compare_duty($sformatf("vec%0d_duty", v), vecs[v].duty);
      end
    end

    // ---- async reset mid-fade with level[3] = 9
    do_reset();
    light_in = 8'h08;
    enable   = 1'b1;
    step();
    light_in = 8'h00;
    while (cyc < 130) step();
    k = 0;
    while (frame_start !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("pre_reset_frame_start", int'(frame_start), 1);
    chk("pre_reset_led3", int'(led_out[3]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_led_out", int'(led_out), 0);
    chk("async_reset_frame_start", int'(frame_start), 0);
    do_reset();
    enable = 1'b1;
    repeat (30) begin
      step();
      chk("post_reset_led_out", int'(led_out), 0);
    end

    // ---- full-on latency: bit 0 high from the 2nd edge onward
    do_reset();
    light_in = 8'h01;
    enable   = 1'b1;
    step();
    chk("latency_edge1_led_out", int'(led_out), 0);
    repeat (45) begin
      step();
      chk("latency_full_on", int'(led_out), 8'h01);
    end

    // ---- pause at level[1] = 6 while light_in toggles
    do_reset();
    light_in = 8'h02;
    enable   = 1'b1;
    step();
    light_in = 8'h00;
    while (cyc < 200) step();
    enable = 1'b0;
    repeat (200) begin
      step();
      chk("pause_led_out", int'(led_out), 0);
      light_in = 8'($urandom);
    end
    chk("pause_cyc_frozen", cyc, 200);
    light_in = 8'h00;
    enable   = 1'b1;
    measure();
    compare_duty("resume_duty", 32'h0000_0060);
    while (cyc < 256) step();
    measure();
    compare_duty("resume_tick_duty", 32'h0000_0030);

    // ---- chaser stream: one-hot shifting every 5 clocks, wrapping 0x80 -> 0x01
    do_reset();
    enable  = 1'b1;
    lastlit = 8'h00;
    for (int e = 1; e <= 85; e++) begin
      light_in = 8'h01 << (((e - 1) / 5) % 8);
      step();
      if (e >= 2) chk("stream_current_on", int'((led_out & lastlit) != 8'h00), 1);
      lastlit = light_in;
    end
    light_in = 8'h00;
    step();
    chk("stream_last_on", int'((led_out & lastlit) != 8'h00), 1);
    measure();
    compare_duty("stream_trail_duty", 32'hFFFF_CCCF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
